univ_shift_reg: RTL
===================

Name: univ_shift_reg

Overview:
- Parametrised universal shift register; successor to the fixed 4-bit serial-in/parallel-out chain.
- Generalised to WIDTH bits, with four modes: hold, shift-left, shift-right and parallel load.
- Serial outputs at both ends, plus a shift counter that flags each completed serial word.
- Sits between bit-serial links and word-parallel datapaths, usable as a SIPO, PISO or bidirectional shifter.

Parameters:
- WIDTH, 8, register width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
- sin_lsb  input  1  serial input entering bit 0 on shift left.
- sin_msb  input  1  serial input entering bit WIDTH-1 on shift right.
- pin  input  WIDTH  parallel load data.
- pout  output  WIDTH  register contents (registered).
- sout_msb  output  1  equals pout[WIDTH-1]; serial out for shift left.
- sout_lsb  output  1  equals pout[0]; serial out for shift right.
- shift_cnt  output  $clog2(WIDTH)  shifts completed in the current word, 0..WIDTH-1.
- word_valid  output  1  one-cycle pulse: WIDTH shifts done since the last load, reset or word boundary.

Behaviour:
- Reset and sampling:
  - All state updates on the rising edge of clk.
  - rst has priority over mode.
  - rst=1: pout=0, shift_cnt=0, word_valid=0 on the next edge. This holds mid-word too; the partial word is discarded.
- Mode 00 hold: pout and shift_cnt unchanged; word_valid=0.
- Mode 10 shift left: pout <= {pout[WIDTH-2:0], sin_lsb}. First bit in ends at the MSB after WIDTH shifts, as in the legacy SIPO.
- Mode 01 shift right: pout <= {sin_msb, pout[WIDTH-1:1]}.
- Mode 11 parallel load: pout <= pin; shift_cnt <= 0; word_valid <= 0.
- Counter, on any shift (mode 01 or 10):
  - If shift_cnt==WIDTH-1: shift_cnt <= 0 and word_valid <= 1 on the same edge. The pulse is visible during the cycle after the WIDTH-th shift edge, aligned with the completed pout.
  - Otherwise shift_cnt <= shift_cnt+1 and word_valid <= 0.
- Back-to-back words: continuous shifting gives word_valid high for exactly one cycle every WIDTH cycles, with no gap cycle.
- Mixed directions: left and right shifts both count toward the same word. Direction changes mid-word are legal and do not reset the counter.
- Hold mid-word: the count is frozen and resumes on the next shift. Holds do not stretch word_valid.
- Load mid-word: the count restarts from 0. Loading on the cycle after word_valid is legal.
- Latency:
  - Parallel load to pout: 1 cycle.
  - Serial bit to pout[WIDTH-1] (left) or pout[0] (right): WIDTH edges.
- sout_msb and sout_lsb are purely combinational taps of pout; no extra register stage.

Optional Feature:
- Macro: USR_PARITY_EN.
- Defined:
  - Adds output port parity (1 bit), registered, equal to the XOR reduction of the next pout. It is always consistent with pout in the same cycle.
  - Reset value 0.
  - Updated in every mode, hold included.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: drive rst=1 for 2 cycles with mode=11, pin=8'hFF -> pout=8'h00, shift_cnt=0, word_valid=0; the load is ignored.
- SIPO left (WIDTH=8): mode=10, shift sin_lsb bits 1,0,1,1,0,0,1,0 on 8 edges -> pout=8'hB2, word_valid=1 for exactly one cycle after the 8th edge, shift_cnt back to 0.
- PISO right: load pin=8'hA5, then 8 cycles of mode=01 with sin_msb=0 -> sout_lsb sequence 1,0,1,0,0,1,0,1; final pout=8'h00; word_valid pulses once.
- Hold and load mid-word:
  - 3 left shifts, 4 holds -> shift_cnt stays 3 throughout the holds.
  - Then load pin=8'h3C -> pout=8'h3C, shift_cnt=0, no word_valid.
- Reset mid-word: after 5 shifts assert rst for 1 cycle -> pout=0, shift_cnt=0; the next 8 shifts produce exactly one word_valid.
- Parity (USR_PARITY_EN):
  - Load 8'h07 -> parity=1.
  - Shift left with sin_lsb=1 -> pout=8'h0F, parity=0.

Source files
------------

// File: rtl/univ_shift_reg.sv
// Parametrised universal shift register: hold, shift left/right, parallel load,
// with a per-word shift counter. Define USR_PARITY_EN to add a registered parity output.
module univ_shift_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 mode,
    input  logic                       sin_lsb,
    input  logic                       sin_msb,
    input  logic [WIDTH-1:0]           pin,
    output logic [WIDTH-1:0]           pout,
    output logic                       sout_msb,
    output logic                       sout_lsb,
    output logic [$clog2(WIDTH)-1:0]   shift_cnt,
    output logic                       word_valid
`ifdef USR_PARITY_EN
    ,
    output logic                       parity
`endif
);

    localparam int unsigned CW = $clog2(WIDTH);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    logic [WIDTH-1:0] pout_nxt;
    logic [CW-1:0]    cnt_nxt;
    logic             wv_nxt;
    logic             is_shift;
    logic             word_end;

    assign sout_msb = pout[WIDTH-1];
    assign sout_lsb = pout[0];

    assign is_shift = (mode == MODE_RIGHT) || (mode == MODE_LEFT);
    assign word_end = (shift_cnt == CW'(WIDTH - 1));

    // Next register contents and word counter for the selected mode
    always_comb begin
        pout_nxt = pout;
        cnt_nxt  = shift_cnt;
        wv_nxt   = 1'b0;
        case (mode)
            MODE_HOLD:  pout_nxt = pout;
            MODE_RIGHT: pout_nxt = {sin_msb, pout[WIDTH-1:1]};
            MODE_LEFT:  pout_nxt = {pout[WIDTH-2:0], sin_lsb};
            MODE_LOAD: begin
                pout_nxt = pin;
                cnt_nxt  = '0;
            end
            default:    pout_nxt = pout;
        endcase
        if (is_shift) begin
            if (word_end) begin
                cnt_nxt = '0;
                wv_nxt  = 1'b1;
            end else begin
                cnt_nxt = shift_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pout       <= '0;
            shift_cnt  <= '0;
            word_valid <= 1'b0;
        end else begin
            pout       <= pout_nxt;
            shift_cnt  <= cnt_nxt;
            word_valid <= wv_nxt;
        end
    end

`ifdef USR_PARITY_EN
    // Parity tracks the value being written so it always matches pout
    always_ff @(posedge clk) begin
        if (rst) begin
            parity <= 1'b0;
        end else begin
            parity <= ^pout_nxt;
        end
    end
`endif

endmodule
